csr_mux_bridge: RTL

CSR_MUX_BRIDGE -- requirements
Module: csr_mux_bridge

---
 rtl/csr_mux_bridge.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_mux_bridge.sv
// MMIO-to-CSR bridge: decodes one request at a time onto NUM_CH CSR target channels
// and returns read data (or an error completion) with the request metadata echoed back.
module csr_mux_bridge #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned MM_ADDR_WIDTH  = 18,
    parameter int unsigned MM_DATA_WIDTH  = 64,
    parameter int unsigned CH_ADDR_BITS   = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [MM_ADDR_WIDTH-1:0]        req_addr,
    input  logic [MM_DATA_WIDTH-1:0]        req_wdata,
    input  logic [MM_DATA_WIDTH/8-1:0]      req_be,
    input  logic [9:0]                      req_tag,
    input  logic [13:0]                     req_len,
    input  logic [15:0]                     req_reqid,
    input  logic [23:0]                     req_lowaddr,
    output logic [NUM_CH-1:0]               csr_write,
    output logic [NUM_CH-1:0]               csr_read,
    output logic [MM_ADDR_WIDTH-1:0]        csr_address,
    output logic [MM_DATA_WIDTH-1:0]        csr_writedata,
    output logic [MM_DATA_WIDTH/8-1:0]      csr_byteenable,
    input  logic [NUM_CH-1:0]               csr_waitrequest,
    input  logic [NUM_CH-1:0]               csr_readdatavalid,
    input  logic [NUM_CH*MM_DATA_WIDTH-1:0] csr_readdata,
    output logic                            cpl_valid,
    input  logic                            cpl_ready,
    output logic [MM_DATA_WIDTH-1:0]        cpl_data,
    output logic [9:0]                      cpl_tag,
    output logic [13:0]                     cpl_len,
    output logic [15:0]                     cpl_reqid,
    output logic [23:0]                     cpl_lowaddr,
    output logic                            cpl_err,
    output logic [15:0]                     err_cnt
);

    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BE_W  = MM_DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_CPL     = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic                       write_q, write_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [15:0]                err_cnt_q, err_cnt_d;
    logic                       req_ready_q, req_ready_d;
    logic [NUM_CH-1:0]          csr_write_q, csr_write_d;
    logic [NUM_CH-1:0]          csr_read_q, csr_read_d;
    logic [MM_ADDR_WIDTH-1:0]   csr_address_q, csr_address_d;
    logic [MM_DATA_WIDTH-1:0]   csr_writedata_q, csr_writedata_d;
    logic [BE_W-1:0]            csr_byteenable_q, csr_byteenable_d;
    logic                       cpl_valid_q, cpl_valid_d;
    logic                       cpl_err_q, cpl_err_d;
    logic [MM_DATA_WIDTH-1:0]   cpl_data_q, cpl_data_d;
    logic [9:0]                 cpl_tag_q, cpl_tag_d;
    logic [13:0]                cpl_len_q, cpl_len_d;
    logic [15:0]                cpl_reqid_q, cpl_reqid_d;
    logic [23:0]                cpl_lowaddr_q, cpl_lowaddr_d;

    logic                       accept;
    logic [SEL_W-1:0]           req_sel;
    logic                       req_sel_ok;
    logic                       sel_wait;
    logic                       sel_rdv;
    logic [MM_DATA_WIDTH-1:0]   sel_data;
    logic                       timeout;
    logic                       err_evt;
    logic                       unused_addr_bits;

    assign accept           = req_valid & req_ready_q;
    assign req_sel          = req_addr[CH_ADDR_BITS +: SEL_W];
    assign req_sel_ok       = {1'b0, req_sel} < (SEL_W + 1)'(NUM_CH);
    assign sel_wait         = csr_waitrequest[sel_q];
    assign sel_rdv          = csr_readdatavalid[sel_q];
    assign sel_data         = csr_readdata[int'(sel_q) * MM_DATA_WIDTH +: MM_DATA_WIDTH];
    assign timeout          = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign unused_addr_bits = ^req_addr;

    // Next-state and registered-output computation
    always_comb begin
        state_d          = state_q;
        sel_d            = sel_q;
        write_d          = write_q;
        cnt_d            = cnt_q;
        err_cnt_d        = err_cnt_q;
        csr_write_d      = csr_write_q;
        csr_read_d       = csr_read_q;
        csr_address_d    = csr_address_q;
        csr_writedata_d  = csr_writedata_q;
        csr_byteenable_d = csr_byteenable_q;
        cpl_err_d        = cpl_err_q;
        cpl_data_d       = cpl_data_q;
        cpl_tag_d        = cpl_tag_q;
        cpl_len_d        = cpl_len_q;
        cpl_reqid_d      = cpl_reqid_q;
        cpl_lowaddr_d    = cpl_lowaddr_q;
        err_evt          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sel_d            = req_sel;
                    write_d          = req_write;
                    cnt_d            = '0;
                    csr_address_d    = MM_ADDR_WIDTH'(req_addr[CH_ADDR_BITS-1:0]);
                    csr_writedata_d  = req_wdata;
                    csr_byteenable_d = req_be;
                    cpl_tag_d        = req_tag;
                    cpl_len_d        = req_len;
                    cpl_reqid_d      = req_reqid;
                    cpl_lowaddr_d    = req_lowaddr;
                    if (req_sel_ok) begin
                        state_d = ST_CMD;
                        if (req_write) begin
                            csr_write_d = NUM_CH'(1) << req_sel;
                        end else begin
                            csr_read_d = NUM_CH'(1) << req_sel;
                        end
                    end else begin
                        // Unmapped channel: writes vanish, reads complete with error data
                        err_evt = 1'b1;
                        if (!req_write) begin
                            state_d    = ST_CPL;
                            cpl_data_d = '1;
                            cpl_err_d  = 1'b1;
                        end
                    end
                end
            end
            ST_CMD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!sel_wait) begin
                    csr_write_d = '0;
                    csr_read_d  = '0;
                    state_d     = write_q ? ST_IDLE : ST_RD_WAIT;
                end else if (timeout) begin
                    csr_write_d = '0;
                    csr_read_d  = '0;
                    err_evt     = 1'b1;
                    if (write_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_CPL;
                        cpl_data_d = '1;
                        cpl_err_d  = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sel_rdv) begin
                    state_d    = ST_CPL;
                    cpl_data_d = sel_data;
                    cpl_err_d  = 1'b0;
                end else if (timeout) begin
                    state_d    = ST_CPL;
                    cpl_data_d = '1;
                    cpl_err_d  = 1'b1;
                    err_evt    = 1'b1;
                end
            end
            ST_CPL: begin
                if (cpl_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_evt && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        // Ready drops for the cycle after any acceptance, so at most one request per two cycles
        req_ready_d = (state_d == ST_IDLE) && !accept;
        cpl_valid_d = (state_d == ST_CPL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            sel_q            <= '0;
            write_q          <= 1'b0;
            cnt_q            <= '0;
            err_cnt_q        <= '0;
            req_ready_q      <= 1'b0;
            csr_write_q      <= '0;
            csr_read_q       <= '0;
            csr_address_q    <= '0;
            csr_writedata_q  <= '0;
            csr_byteenable_q <= '0;
            cpl_valid_q      <= 1'b0;
            cpl_err_q        <= 1'b0;
            cpl_data_q       <= '0;
            cpl_tag_q        <= '0;
            cpl_len_q        <= '0;
            cpl_reqid_q      <= '0;
            cpl_lowaddr_q    <= '0;
        end else begin
            state_q          <= state_d;
            sel_q            <= sel_d;
            write_q          <= write_d;
            cnt_q            <= cnt_d;
            err_cnt_q        <= err_cnt_d;
            req_ready_q      <= req_ready_d;
            csr_write_q      <= csr_write_d;
            csr_read_q       <= csr_read_d;
            csr_address_q    <= csr_address_d;
            csr_writedata_q  <= csr_writedata_d;
            csr_byteenable_q <= csr_byteenable_d;
            cpl_valid_q      <= cpl_valid_d;
            cpl_err_q        <= cpl_err_d;
            cpl_data_q       <= cpl_data_d;
            cpl_tag_q        <= cpl_tag_d;
            cpl_len_q        <= cpl_len_d;
            cpl_reqid_q      <= cpl_reqid_d;
            cpl_lowaddr_q    <= cpl_lowaddr_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign csr_write      = csr_write_q;
    assign csr_read       = csr_read_q;
    assign csr_address    = csr_address_q;
    assign csr_writedata  = csr_writedata_q;
    assign csr_byteenable = csr_byteenable_q;
    assign cpl_valid      = cpl_valid_q;
    assign cpl_err        = cpl_err_q;
    assign cpl_data       = cpl_data_q;
    assign cpl_tag        = cpl_tag_q;
    assign cpl_len        = cpl_len_q;
    assign cpl_reqid      = cpl_reqid_q;
    assign cpl_lowaddr    = cpl_lowaddr_q;
    assign err_cnt        = err_cnt_q;

endmodule
